// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the byte-serial RAM port arbiter.
//   - transaction length encodings and the byte-index helper
//   - owner codes reported on if_or_mem_o
//   - FSM state encoding
//   - default address of the host I/O byte port
package mem_arbiter_pkg;

   localparam logic [31:0] IoAddrDefault = 32'h0003_0000;

   localparam logic [1:0] LenByte = 2'b00;
   localparam logic [1:0] LenHalf = 2'b01;
   localparam logic [1:0] LenWord = 2'b11;

   localparam logic [1:0] OwnNone = 2'b00;
   localparam logic [1:0] OwnIf   = 2'b01;
   localparam logic [1:0] OwnMem  = 2'b10;

   typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

   // Index of the final byte of a transaction; 2'b10 is treated as a word.
   function automatic logic [1:0] last_idx(input logic [1:0] len);
      unique case (len)
         LenByte: last_idx = 2'd0;
         LenHalf: last_idx = 2'd1;
         default: last_idx = 2'd3;
      endcase
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Byte-serial RAM port arbiter between the IF stage and the MEM stage.
//   clk, rst (sync, active-high), rdy (global enable, low freezes state)
//   if_request/if_addr       : IF byte fetch, one address per cycle
//   if_data_o/if_or_mem_o    : byte returned to IF, owner of ram_din this cycle
//   mem_req_i..mem_wdata_i   : MEM 1/2/4-byte transaction, held until mem_done_o
//   mem_rdata_o/mem_done_o   : assembled load word, one-cycle completion pulse
//   stall_o                  : MEM owns (or is claiming) the port
//   ram_din/ram_dout/ram_a/ram_wr : RAM byte port, read data one cycle after ram_a
//   io_full                  : host I/O buffer full, back-pressures writes to IO_ADDR
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter logic [31:0] IO_ADDR = IoAddrDefault
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        if_request,
   input  logic [31:0] if_addr,
   output logic [7:0]  if_data_o,
   output logic [1:0]  if_or_mem_o,
   input  logic        mem_req_i,
   input  logic        mem_we_i,
   input  logic [1:0]  mem_len_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_wdata_i,
   output logic [31:0] mem_rdata_o,
   output logic        mem_done_o,
   output logic        stall_o,
   input  logic [7:0]  ram_din,
   output logic [7:0]  ram_dout,
   output logic [31:0] ram_a,
   output logic        ram_wr,
   input  logic        io_full
);

   state_e      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [1:0]  last_q, last_d;
   logic [31:0] base_q, base_d;
   logic [31:0] wdata_q, wdata_d;
   logic [23:0] shift_q, shift_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  owner_q, owner_d;
   logic        issued_q, issued_d;  // RD: every address sent, next cycle captures the last byte
   logic [31:0] ram_a_q, ram_a_d;    // address driven on the last enabled cycle

   logic [31:0] byte_addr;
   logic        io_block;
   logic        wr_en;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      last_d    = last_q;
      base_d    = base_q;
      wdata_d   = wdata_q;
      shift_d   = shift_q;
      rdata_d   = rdata_q;
      issued_d  = issued_q;
      owner_d   = OwnNone;
      ram_a_d   = '0;
      ram_dout  = '0;
      wr_en     = 1'b0;
      byte_addr = base_q + {30'b0, cnt_q};
      io_block  = (byte_addr == IO_ADDR) && io_full;

      unique case (state_q)
         StIdle: begin
            if (mem_req_i) begin
               state_d  = mem_we_i ? StWr : StRd;
               base_d   = mem_addr_i;
               last_d   = last_idx(mem_len_i);
               wdata_d  = mem_wdata_i;
               cnt_d    = '0;
               issued_d = 1'b0;
            end else if (if_request) begin
               ram_a_d = if_addr;
               owner_d = OwnIf;
            end
         end
         StRd: begin
            if (!issued_q) begin
               ram_a_d = byte_addr;
               owner_d = OwnMem;
               // ram_din now carries the byte addressed on the previous cycle
               if (cnt_q != 2'd0) shift_d = {ram_din, shift_q[23:8]};
               if (cnt_q == last_q) issued_d = 1'b1;
               else                 cnt_d    = cnt_q + 2'd1;
            end else begin
               case (last_q)
                  2'd0:    rdata_d = {24'b0, ram_din};
                  2'd1:    rdata_d = {16'b0, ram_din, shift_q[23:16]};
                  default: rdata_d = {ram_din, shift_q};
               endcase
               state_d = StDone;
            end
         end
         StWr: begin
            ram_a_d  = byte_addr;
            ram_dout = wdata_q[{cnt_q, 3'b000} +: 8];
            if (!io_block) begin
               wr_en = 1'b1;
               if (cnt_q == last_q) state_d = StDone;
               else                 cnt_d   = cnt_q + 2'd1;
            end
         end
         StDone: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         last_q   <= '0;
         base_q   <= '0;
         wdata_q  <= '0;
         shift_q  <= '0;
         rdata_q  <= '0;
         issued_q <= 1'b0;
         owner_q  <= OwnNone;
         ram_a_q  <= '0;
      end else if (rdy) begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         last_q   <= last_d;
         base_q   <= base_d;
         wdata_q  <= wdata_d;
         shift_q  <= shift_d;
         rdata_q  <= rdata_d;
         issued_q <= issued_d;
         owner_q  <= owner_d;
         ram_a_q  <= ram_a_d;
      end
   end

   // While frozen, keep the previous address on the RAM so ram_din still
   // holds the byte that is due for capture once rdy returns.
   assign ram_a       = rdy ? ram_a_d : ram_a_q;
   assign ram_wr      = wr_en & rdy & ~rst;
   assign if_or_mem_o = owner_q;
   assign if_data_o   = (owner_q == OwnIf) ? ram_din : 8'h00;
   assign mem_rdata_o = rdata_q;
   assign mem_done_o  = (state_q == StDone) & rdy;
   // Low in StDone so IF re-issues the byte it lost to MEM.
   assign stall_o     = (state_q == StRd) | (state_q == StWr) |
                        ((state_q == StIdle) & mem_req_i);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

   localparam logic [31:0] IoAddr = 32'h0003_0000;

   logic        clk = 1'b0;
   logic        rst, rdy, if_request;
   logic [31:0] if_addr;
   logic [7:0]  if_data_o;
   logic [1:0]  if_or_mem_o;
   logic        mem_req_i, mem_we_i;
   logic [1:0]  mem_len_i;
   logic [31:0] mem_addr_i, mem_wdata_i, mem_rdata_o;
   logic        mem_done_o, stall_o;
   logic [7:0]  ram_din, ram_dout;
   logic [31:0] ram_a;
   logic        ram_wr, io_full;

   always #5 clk = ~clk;

   mem_arbiter #(.IO_ADDR(IoAddr)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .if_request(if_request), .if_addr(if_addr),
      .if_data_o(if_data_o), .if_or_mem_o(if_or_mem_o),
      .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_len_i(mem_len_i),
      .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
      .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o), .stall_o(stall_o),
      .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr),
      .io_full(io_full)
   );

   // Sparse address space folded onto 4 KiB: low region, top-of-memory wrap region, I/O port.
   function automatic logic [11:0] ram_idx(input logic [31:0] a);
      if (a[31:16] == 16'h0003)   return {4'h8, a[7:0]};
      if (a[31:12] == 20'hFFFFF)  return {2'b11, a[9:0]};
      return {1'b0, a[10:0]};
   endfunction

   function automatic int nbytes(input logic [1:0] len);
      return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
   endfunction

   // RAM environment: synchronous read, data one cycle after address.
   logic [7:0]  ram_arr [4096];
   logic        ram_clr, pre_we;
   logic [31:0] pre_a;
   logic [7:0]  pre_d;
   always @(posedge clk) begin
      if (ram_clr) begin
         for (int i = 0; i < 4096; i++) ram_arr[i] <= 8'h00;
      end else begin
         if (pre_we) ram_arr[ram_idx(pre_a)] <= pre_d;
         if (ram_wr) ram_arr[ram_idx(ram_a)] <= ram_dout;
      end
      ram_din <= ram_arr[ram_idx(ram_a)];
   end

   // Reference memory contents as seen by the architecture.
   logic [7:0] model_mem [4096];

   typedef struct packed {
      logic        is_load;
      logic [31:0] data;
      int          lat;
      logic [63:0] t0;
   } done_t;

   logic [7:0]  if_q [$];
   logic [39:0] wr_q [$];
   done_t       done_q [$];

   int   vectors = 0;
   int   miscompares = 0;
   logic mem_active = 1'b0;
   logic chk_idle = 1'b0;
   logic chk_end = 1'b0;

   // Monitor / scoreboard
   logic [7:0]  m_exp8;
   logic [39:0] m_wexp;
   done_t       m_d;
   int          m_meas;
   int          wait_cyc = 0;
   always @(negedge clk) begin
      if (!rst) begin
         if (if_or_mem_o == 2'b01) begin
            vectors++;
            if (if_q.size() == 0) begin
               miscompares++;
               $display("FAIL if_owner: if_or_mem_o=01 data=%h, no IF byte outstanding", if_data_o);
            end else begin
               m_exp8 = if_q.pop_front();
               if (if_data_o !== m_exp8) begin
                  miscompares++;
                  $display("FAIL if_data: got %h want %h", if_data_o, m_exp8);
               end
            end
         end
         if (ram_wr) begin
            vectors++;
            if (wr_q.size() == 0) begin
               miscompares++;
               $display("FAIL ram_write: unexpected write a=%h d=%h", ram_a, ram_dout);
            end else begin
               m_wexp = wr_q.pop_front();
               if ({ram_a, ram_dout} !== m_wexp || (ram_a == IoAddr && io_full)) begin
                  miscompares++;
                  $display("FAIL ram_write: got a=%h d=%h io_full=%b want a=%h d=%h",
                           ram_a, ram_dout, io_full, m_wexp[39:8], m_wexp[7:0]);
               end
            end
         end
         if (mem_done_o) begin
            vectors++;
            if (done_q.size() == 0) begin
               miscompares++;
               $display("FAIL done_unexpected: mem_done_o=1 rdata=%h", mem_rdata_o);
            end else begin
               m_d = done_q.pop_front();
               m_meas = int'(($time - m_d.t0 - 4) / 10);
               if (m_meas != m_d.lat) begin
                  miscompares++;
                  $display("FAIL done_latency: got %0d want %0d", m_meas, m_d.lat);
               end else if (m_d.is_load && mem_rdata_o !== m_d.data) begin
                  miscompares++;
                  $display("FAIL load_data: got %h want %h", mem_rdata_o, m_d.data);
               end else if (stall_o !== 1'b0) begin
                  miscompares++;
                  $display("FAIL stall_done: got %b want 0", stall_o);
               end
            end
         end else begin
            vectors++;
            if (stall_o !== (mem_active | mem_req_i)) begin
               miscompares++;
               $display("FAIL stall: got %b want %b", stall_o, mem_active | mem_req_i);
            end
         end
         if (mem_active) begin
            wait_cyc++;
            if (wait_cyc == 50) begin
               vectors++;
               miscompares++;
               $display("FAIL mem_timeout: no mem_done_o after %0d cycles, want done", wait_cyc);
            end
         end else begin
            wait_cyc = 0;
         end
         if (chk_idle) begin
            vectors++;
            if ({if_data_o, if_or_mem_o, mem_rdata_o, mem_done_o, stall_o, ram_wr, ram_a,
                 ram_dout} !== '0) begin
               miscompares++;
               $display("FAIL reset_state: ifd=%h own=%b rd=%h done=%b st=%b wr=%b a=%h do=%h want all 0",
                        if_data_o, if_or_mem_o, mem_rdata_o, mem_done_o, stall_o, ram_wr, ram_a,
                        ram_dout);
            end
         end
         if (chk_end) begin
            vectors++;
            if (if_q.size() != 0 || wr_q.size() != 0 || done_q.size() != 0) begin
               miscompares++;
               $display("FAIL drain: left if=%0d wr=%0d done=%0d want 0 0 0",
                        if_q.size(), wr_q.size(), done_q.size());
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic poke(input logic [31:0] a, input logic [7:0] d);
      model_mem[ram_idx(a)] = d;
      pre_a = a;
      pre_d = d;
      pre_we = 1'b1;
      tick();
      pre_we = 1'b0;
   endtask

   task automatic if_fetch(input logic [31:0] a);
      tick();
      if_request = 1'b1;
      if_addr = a;
      if_q.push_back(model_mem[ram_idx(a)]);
   endtask

   task automatic if_burst(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         if_request = ($urandom_range(0, 3) != 0);
         if_addr = 32'($urandom_range(0, 'h3ff));
         if (if_request) if_q.push_back(model_mem[ram_idx(if_addr)]);
      end
      tick();
      if_request = 1'b0;
   endtask

   task automatic run_mem(input logic we, input logic [1:0] len, input logic [31:0] base,
                          input logic [31:0] wd, input int io_blk, input int p_at,
                          input int p_len, input logic hold_if, input logic [31:0] if_a);
      int          n, cyc;
      logic [31:0] a, exp;
      logic        is_io;
      done_t       d;
      n = nbytes(len);
      exp = '0;
      is_io = (base == IoAddr);
      for (int k = 0; k < n; k++) begin
         a = base + 32'(k);
         if (we) begin
            wr_q.push_back({a, wd[8*k +: 8]});
            model_mem[ram_idx(a)] = wd[8*k +: 8];
         end else begin
            exp |= {24'b0, model_mem[ram_idx(a)]} << (8 * k);
         end
      end
      tick();
      if_request  = 1'b0;
      mem_req_i   = 1'b1;
      mem_we_i    = we;
      mem_len_i   = len;
      mem_addr_i  = base;
      mem_wdata_i = wd;
      if_request  = hold_if;
      if_addr     = if_a;
      io_full     = is_io ? 1'b1 : 1'($urandom_range(0, 1));
      d.is_load   = !we;
      d.data      = exp;
      d.lat       = (we ? n + 1 + io_blk : n + 2) + p_len;
      d.t0        = $time;
      done_q.push_back(d);
      mem_active  = 1'b1;
      cyc = 0;
      forever begin
         tick();
         cyc++;
         rdy = !(p_len > 0 && cyc >= p_at && cyc < p_at + p_len);
         io_full = is_io ? (cyc <= io_blk) : 1'($urandom_range(0, 1));
         #1;
         if (mem_done_o || cyc >= 60) break;
      end
      mem_req_i  = 1'b0;
      if_request = 1'b0;
      mem_active = 1'b0;
      rdy        = 1'b1;
      io_full    = 1'b0;
   endtask

   logic        r_we;
   logic [1:0]  r_len;
   logic [31:0] r_base;
   int          r_sel, r_io, r_pat, r_plen;

   initial begin
      rst = 1'b1; rdy = 1'b1; if_request = 1'b0; if_addr = '0;
      mem_req_i = 1'b0; mem_we_i = 1'b0; mem_len_i = '0; mem_addr_i = '0; mem_wdata_i = '0;
      io_full = 1'b0; ram_clr = 1'b1; pre_we = 1'b0; pre_a = '0; pre_d = '0;
      for (int i = 0; i < 4096; i++) model_mem[i] = 8'h00;
      repeat (2) tick();
      ram_clr = 1'b0;
      rst = 1'b0;
      chk_idle = 1'b1;
      tick();
      chk_idle = 1'b0;

      // IF-only fetch of an instruction word
      poke(32'h0, 8'h13); poke(32'h1, 8'h00); poke(32'h2, 8'h00); poke(32'h3, 8'h93);
      for (int i = 0; i < 4; i++) if_fetch(32'(i));
      tick();
      if_request = 1'b0;

      // Word load
      poke(32'h100, 8'h78); poke(32'h101, 8'h56); poke(32'h102, 8'h34); poke(32'h103, 8'h12);
      run_mem(1'b0, 2'b11, 32'h100, '0, 0, 1, 0, 1'b0, '0);

      // Half store
      run_mem(1'b1, 2'b01, 32'h202, 32'h0000_BEEF, 0, 1, 0, 1'b0, '0);
      run_mem(1'b0, 2'b01, 32'h202, '0, 0, 1, 0, 1'b0, '0);

      // IF and MEM collide; IF re-fetches afterwards
      run_mem(1'b0, 2'b11, 32'h100, '0, 0, 1, 0, 1'b1, 32'h3);
      if_fetch(32'h3);
      tick();
      if_request = 1'b0;

      // Byte store to the I/O port under back-pressure
      run_mem(1'b1, 2'b00, IoAddr, 32'h0000_005A, 3, 1, 0, 1'b0, '0);

      // rdy low for two cycles mid load
      run_mem(1'b0, 2'b11, 32'h100, '0, 0, 2, 2, 1'b0, '0);

      // Reset lands on the third address cycle of a word load
      tick();
      mem_req_i = 1'b1; mem_we_i = 1'b0; mem_len_i = 2'b11; mem_addr_i = 32'h100;
      mem_active = 1'b1;
      repeat (3) tick();
      rst = 1'b1;
      mem_req_i = 1'b0;
      mem_active = 1'b0;
      tick();
      rst = 1'b0;
      chk_idle = 1'b1;
      tick();
      chk_idle = 1'b0;
      repeat (8) tick();

      // Randomised mix of IF bursts and MEM transactions
      for (int t = 0; t < 150; t++) begin
         if ($urandom_range(0, 2) == 0) begin
            if_burst(int'($urandom_range(1, 6)));
         end else begin
            r_sel  = int'($urandom_range(0, 9));
            r_we   = 1'($urandom_range(0, 1));
            r_len  = 2'($urandom_range(0, 3));
            r_io   = 0;
            r_pat  = 1;
            r_plen = 0;
            if (r_sel == 0) begin
               r_base = IoAddr;
               r_we   = 1'b1;
               r_io   = int'($urandom_range(0, 3));
            end else begin
               r_base = (r_sel == 1) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                     : 32'($urandom_range(0, 'h3ff));
               if ($urandom_range(0, 3) == 0) begin
                  r_plen = int'($urandom_range(1, 3));
                  r_pat  = int'($urandom_range(1, nbytes(r_len)));
               end
            end
            run_mem(r_we, r_len, r_base, $urandom, r_io, r_pat, r_plen,
                    1'($urandom_range(0, 1)), 32'($urandom_range(0, 'h3ff)));
         end
      end

      repeat (3) tick();
      chk_end = 1'b1;
      tick();
      chk_end = 1'b0;
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
